wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's writeback result and results returned by a multi-cycle execution unit (multiply/divide). Multi-cycle results are queued in a small FIFO. Pipeline writes have priority, and a starvation counter forces a queued result through by stalling the pipeline for one cycle. The block sits between the writeback mux (data and destination register) and the register file write port.

## Interface
- DEPTH, 2, multi-cycle result FIFO entries; power of two, ≥2
- STARVE_MAX, 4, denied cycles tolerated by FIFO head before forced grant; ≥1
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pipe_valid  in  1  writeback stage holds a valid instruction
- pipe_we  in  1  that instruction writes a register
- pipe_rd  in  5  destination register (already 31 for calls)
- pipe_data  in  32  writeback data
- pipe_stall  out  1  pipeline must hold its writeback inputs this cycle; pipeline write not taken
- mc_valid  in  1  multi-cycle unit presents a result
- mc_rd  in  5  its destination register
- mc_data  in  32  its data
- mc_ready  out  1  FIFO can accept; transfer on mc_valid && mc_ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)

## Operation
- pw = pipe_valid && pipe_we; empty/full from FIFO count (0..DEPTH).
- mc_ready = !full && !reset, combinational from registered count. No push when full, even if a pop happens in the same cycle.
- Grant decision, every cycle:
  - empty: grant pipe if pw; else no write. An mc result accepted this cycle is only enqueued and is never bypassed.
  - !empty && !pw: grant FIFO head (pop).
  - !empty && pw && wait_cnt < STARVE_MAX: grant pipe; wait_cnt += 1.
  - !empty && pw && wait_cnt ≥ STARVE_MAX: grant FIFO head (pop); pipe_stall = 1.
- pipe_stall is asserted only in the forced case. It is combinational from wait_cnt, count and pw. While it is high, the pipeline repeats the same pw/rd/data next cycle, and that next cycle the pipe is granted (wait_cnt is 0, or FIFO empty).
- wait_cnt: 0 on reset, on any pop, and whenever FIFO empty; saturates at STARVE_MAX.
- Push and pop in the same cycle are allowed when not full. Count is unchanged; head advances; new entry goes to tail.
- Register ordering (an mc result vs a younger pipe write to the same rd) is guaranteed by the issue stage. This block does no rd comparison.
- rd = 0 is written like any other register; no special-casing.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO count 0, wait_cnt 0. mc_ready=0 and pipe_stall=0 during reset.
- Reset mid-operation flushes all queued results (lost) and cancels the in-flight grant; rf_we is 0 in the cycle after reset.
- Pipe grant latency: rf_* reflect pipe_rd/pipe_data 1 cycle after the granted cycle.
- MC latency: at least 2 cycles from accept edge to rf_we (enqueue, then pop, then registered output). Worst case while pipe writes every cycle is 2+STARVE_MAX cycles for head.
- At most one rf write per cycle; rf_we=0 in cycles with no grant.
- FIFO pointers wrap modulo DEPTH; count width log2(DEPTH)+1.

## Test plan
- Reset: hold reset 2 cycles with mc_valid=1, pw=1 → rf_we=0, mc_ready=0, pipe_stall=0; no enqueue. First cycle after reset, pw rd=5 data=0x11 → next cycle rf_we=1, waddr=5, wdata=0x11.
- Idle MC path: pw=0; push mc rd=7 data=0xABCD → rf write (7, 0xABCD) exactly 2 cycles after accept edge.
- Starvation, STARVE_MAX=4: push mc rd=3; pw=1 continuously with rd=9.
  - First 4 cycles after enqueue: pipe writes to r9.
  - 5th cycle: pipe_stall=1, next rf write is r3; wait_cnt returns to 0.
  - Following cycle: held pipe write to r9 is taken.
- Full FIFO (DEPTH=2): pw=1, push 3 mc results back-to-back → mc_ready low after 2nd accept. 3rd result is held by the unit and accepted only after the first forced pop. Write order to rf is r1, r2, r3 for mc rd=1,2,3.
- Simultaneous push/pop at count=1 with pw=0: pop head (rd=4) and push rd=6 in the same cycle → count stays 1; writes r4 then r6 on consecutive cycles.
- Mid-operation reset with 2 entries queued → after reset, no rf_we for queued rd values; count 0, mc_ready=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline's
// writeback result and results returned by a multi-cycle execution unit.
// Multi-cycle results are queued in a small FIFO. Pipeline writes win by
// default. Once the FIFO head has been passed over STARVE_MAX times, it is
// forced through and the pipeline is stalled for one cycle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pipe_valid/pipe_we  writeback stage holds a register-writing instruction
//   pipe_rd/pipe_data   writeback destination and data
//   pipe_stall          pipeline must hold its writeback inputs this cycle
//   mc_valid/mc_rd/mc_data  multi-cycle unit result (valid/ready handshake)
//   mc_ready            FIFO can accept a result
//   rf_we/rf_waddr/rf_wdata registered register-file write port
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mc_valid,
    input  logic [4:0]        mc_rd,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

    logic [4:0]        rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [WW-1:0]     wait_cnt;

    logic pw, empty, full, starved, grant_pipe, pop, push;

    logic              vld_p1;
    logic [4:0]        waddr_p1;
    logic [DATA_W-1:0] wdata_p1;

    function automatic logic [WW-1:0] wait_sat_inc(input logic [WW-1:0] v);
        return (v >= WAIT_MAX) ? WAIT_MAX : v + WW'(1);
    endfunction

    // Stage 0: grant decision, combinational from registered FIFO state
    always_comb begin
        pw         = pipe_valid && pipe_we;
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        // Forced grant: the head has waited long enough and the pipe is contending.
        starved    = !empty && pw && (wait_cnt >= WAIT_MAX);
        grant_pipe = pw && !starved;
        pop        = !empty && (!pw || starved);
        push       = mc_valid && mc_ready;
    end

    assign mc_ready   = !full && !reset;
    assign pipe_stall = starved && !reset;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= mc_rd;
            data_mem[tail] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Only a head that is actually being passed over accumulates wait.
            if (pop || empty)
                wait_cnt <= '0;
            else if (grant_pipe)
                wait_cnt <= wait_sat_inc(wait_cnt);
        end
    end

    // Stage 1: registered register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else if (grant_pipe) begin
            vld_p1   <= 1'b1;
            waddr_p1 <= pipe_rd;
            wdata_p1 <= pipe_data;
        end else if (pop) begin
            vld_p1   <= 1'b1;
            waddr_p1 <= rd_mem[head];
            wdata_p1 <= data_mem[head];
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_rd(pipe_rd),
        .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h88;
        mc_valid = 1'b1; mc_rd = 5'd2; mc_data = 32'h22;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({rf_we, mc_ready, pipe_stall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got we/ready/stall=%b expected 000", i, {rf_we, mc_ready, pipe_stall});
            end
        end
        checks++;
        if ({rf_waddr, rf_wdata} !== 37'd0) begin
            errors++;
            $display("FAIL reset_regs: got waddr=%0d wdata=%h expected 0/0", rf_waddr, rf_wdata);
        end
        reset = 1'b0; mc_valid = 1'b0; pipe_rd = 5'd5; pipe_data = 32'h11;
        settle();
        checks++;
        if ({mc_ready, pipe_stall} !== 2'b10) begin
            errors++;
            $display("FAIL reset_no_enqueue: got ready/stall=%b expected 10", {mc_ready, pipe_stall});
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h11}) begin
            errors++;
            $display("FAIL reset_first_write: got we=%b rd=%0d data=%h expected 1/5/11", rf_we, rf_waddr, rf_wdata);
        end
        pipe_valid = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_after: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_pipe_b2b();
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEADBEEF;
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL pipe_r0: got we=%b rd=%0d data=%h expected 1/0/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        pipe_rd = 5'd31; pipe_data = 32'h12345678;
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h12345678}) begin
            errors++;
            $display("FAIL pipe_r31: got we=%b rd=%0d data=%h expected 1/31/12345678", rf_we, rf_waddr, rf_wdata);
        end
        pipe_we = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL pipe_no_we: got we=%b expected 0", rf_we);
        end
        pipe_valid = 1'b0; pipe_we = 1'b1;
    endtask

    task automatic test_idle_mc();
        pipe_valid = 1'b0;
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'hABCD;
        settle();
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 1", mc_ready);
        end
        step();
        mc_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_bypass: got we=%b expected 0", rf_we);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hABCD}) begin
            errors++;
            $display("FAIL idle_mc_write: got we=%b rd=%0d data=%h expected 1/7/abcd", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_single_write: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_starvation();
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h99;
        mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h33;
        settle();
        step();
        mc_valid = 1'b0;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
            errors++;
            $display("FAIL starve_accept_cycle: got we=%b rd=%0d data=%h expected 1/9/99", rf_we, rf_waddr, rf_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (pipe_stall !== 1'b0) begin
                errors++;
                $display("FAIL starve_early_stall[%0d]: got %b expected 0", i, pipe_stall);
            end
            step();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
                errors++;
                $display("FAIL starve_pipe[%0d]: got we=%b rd=%0d data=%h expected 1/9/99", i, rf_we, rf_waddr, rf_wdata);
            end
        end
        settle();
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL starve_stall: got %b expected 1", pipe_stall);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
            errors++;
            $display("FAIL starve_forced: got we=%b rd=%0d data=%h expected 1/3/33", rf_we, rf_waddr, rf_wdata);
        end
        settle();
        checks++;
        if (pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_release: got %b expected 0", pipe_stall);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
            errors++;
            $display("FAIL starve_held_pipe: got we=%b rd=%0d data=%h expected 1/9/99", rf_we, rf_waddr, rf_wdata);
        end
        pipe_valid = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL starve_drained: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_full();
        logic [36:0] got [4];
        int n = 0;
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h20;
        mc_valid = 1'b1; mc_rd = 5'd1; mc_data = 32'h101;
        settle();
        step();
        mc_rd = 5'd2; mc_data = 32'h102;
        settle();
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_second_ready: got %b expected 1", mc_ready);
        end
        step();
        mc_rd = 5'd3; mc_data = 32'h103;
        settle();
        checks++;
        if (mc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_low: got %b expected 0", mc_ready);
        end
        step(); step(); step();
        settle();
        checks++;
        if ({pipe_stall, mc_ready} !== 2'b10) begin
            errors++;
            $display("FAIL full_forced_cycle: got stall/ready=%b expected 10", {pipe_stall, mc_ready});
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h101}) begin
            errors++;
            $display("FAIL full_first_pop: got we=%b rd=%0d data=%h expected 1/1/101", rf_we, rf_waddr, rf_wdata);
        end
        settle();
        checks++;
        if ({pipe_stall, mc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL full_third_accept: got stall/ready=%b expected 01", {pipe_stall, mc_ready});
        end
        step();
        mc_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 12) pipe_valid = 1'b0;
            step();
            if (rf_we && rf_waddr != 5'd20) begin
                if (n < 4) got[n] = {rf_waddr, rf_wdata};
                n++;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL full_mc_count: got %0d mc writes expected 2", n);
        end else begin
            checks++;
            if (got[0] !== {5'd2, 32'h102} || got[1] !== {5'd3, 32'h103}) begin
                errors++;
                $display("FAIL full_order: got %h,%h expected rd2/102 then rd3/103", got[0], got[1]);
            end
        end
    endtask

    task automatic test_push_pop();
        pipe_valid = 1'b0;
        mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
        settle();
        step();
        mc_rd = 5'd6; mc_data = 32'h66;
        settle();
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_ready: got %b expected 1", mc_ready);
        end
        step();
        mc_valid = 1'b0;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin
            errors++;
            $display("FAIL pp_first: got we=%b rd=%0d data=%h expected 1/4/44", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h66}) begin
            errors++;
            $display("FAIL pp_second: got we=%b rd=%0d data=%h expected 1/6/66", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL pp_empty: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_reset_mid();
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h20;
        mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA;
        settle();
        step();
        mc_rd = 5'd11; mc_data = 32'hB;
        step();
        mc_valid = 1'b0;
        reset = 1'b1;
        settle();
        checks++;
        if ({mc_ready, pipe_stall} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready/stall=%b expected 00", {mc_ready, pipe_stall});
        end
        step();
        reset = 1'b0;
        pipe_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cancel: got we=%b expected 0", rf_we);
        end
        settle();
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b expected 1", mc_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_flushed[%0d]: got we=%b rd=%0d expected no write", i, rf_we, rf_waddr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pipe_b2b();
        test_idle_mc();
        test_starvation();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
